// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI FSM encodings, default clock divider and byte width
package spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_XFER = 3'd1,
      ST_WAIT = 3'd2,
      ST_DONE = 3'd3,
      ST_GAP  = 3'd4
   } spi_state_e;

   localparam int SPI_CLK_DIV_DEFAULT = 4;
   localparam int SPI_BYTE_W          = 8;

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - half-period counter producing sclk and one-cycle rise/fall strobes
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic sclk,
   output logic rise,
   output logic fall
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          sclk_q, sclk_d;
   logic          wrap;

   // The strobes mark the cycle whose closing edge moves sclk, so the
   // master can act on the same edge that changes the pin.
   assign wrap = en && !clr && (cnt_q == CNT_MAX);
   assign rise = wrap && !sclk_q;
   assign fall = wrap && sclk_q;
   assign sclk = sclk_q;

   // Count half periods and toggle sclk on each wrap; clear parks sclk low.
   always_comb begin
      cnt_d  = cnt_q;
      sclk_d = sclk_q;
      if (clr) begin
         cnt_d  = '0;
         sclk_d = 1'b0;
      end else if (en) begin
         if (wrap) begin
            cnt_d  = '0;
            sclk_d = !sclk_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Counter and sclk registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-0 MSB-first SPI master; SPI_MASTER_LOOPBACK_EN samples mosi instead of miso
module spi_master
   import spi_pkg::*;
#(
   parameter int CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [SPI_BYTE_W-1:0] tx_data,
   input  logic                  tx_last,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [SPI_BYTE_W-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy,
   output logic                  sclk,
   output logic                  cs,
   output logic                  mosi,
   input  logic                  miso
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] HOLD_MAX = CW'(CLK_DIV - 1);

   spi_state_e            state_q, state_d;
   logic [SPI_BYTE_W-2:0] tx_shift_q, tx_shift_d;
   logic [SPI_BYTE_W-1:0] rx_shift_q, rx_shift_d;
   logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
   logic [2:0]            bit_cnt_q, bit_cnt_d;
   logic [CW-1:0]         hold_cnt_q, hold_cnt_d;
   logic                  last_q, last_d;
   logic                  cs_q, cs_d;
   logic                  mosi_q, mosi_d;
   logic                  rx_pend_q, rx_pend_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  accept;
   logic                  clk_en, clk_clr;
   logic                  sclk_rise, sclk_fall;
   logic                  miso_src;

`ifdef SPI_MASTER_LOOPBACK_EN
   assign miso_src = mosi_q;
`else
   assign miso_src = miso;
`endif

   assign clk_en  = (state_q == ST_XFER);
   assign clk_clr = !clk_en;

   spi_clk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (clk_en),
      .clr  (clk_clr),
      .sclk (sclk),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   assign tx_ready = (state_q == ST_IDLE) || (state_q == ST_WAIT);
   assign accept   = tx_valid && tx_ready;
   assign busy     = (state_q != ST_IDLE);
   assign cs       = cs_q;
   assign mosi     = mosi_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;

   // Next state, shift registers and registered pin values.
   always_comb begin
      state_d    = state_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      bit_cnt_d  = bit_cnt_q;
      hold_cnt_d = '0;
      last_d     = last_q;
      mosi_d     = mosi_q;
      rx_pend_d  = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_WAIT: begin
            if (accept) begin
               tx_shift_d = tx_data[SPI_BYTE_W-2:0];
               mosi_d     = tx_data[SPI_BYTE_W-1];
               last_d     = tx_last;
               bit_cnt_d  = '0;
               state_d    = ST_XFER;
            end
         end
         ST_XFER: begin
            if (sclk_rise) begin
               rx_shift_d = {rx_shift_q[SPI_BYTE_W-2:0], miso_src};
               bit_cnt_d  = bit_cnt_q + 3'd1;
               rx_pend_d  = (bit_cnt_q == 3'd7);
            end
            // The bit counter has wrapped to 0 only after the 8th rise,
            // so a fall seen with 0 is the last one of the byte.
            if (sclk_fall) begin
               if (bit_cnt_q == 3'd0) begin
                  state_d = last_q ? ST_DONE : ST_WAIT;
               end else begin
                  mosi_d     = tx_shift_q[SPI_BYTE_W-2];
                  tx_shift_d = {tx_shift_q[SPI_BYTE_W-3:0], 1'b0};
               end
            end
         end
         ST_DONE: begin
            if (hold_cnt_q == HOLD_MAX) state_d = ST_GAP;
            else                         hold_cnt_d = hold_cnt_q + 1'b1;
         end
         ST_GAP: begin
            if (hold_cnt_q == HOLD_MAX) state_d = ST_IDLE;
            else                         hold_cnt_d = hold_cnt_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      cs_d       = (state_d == ST_IDLE) || (state_d == ST_GAP);
      rx_valid_d = rx_pend_q;
      rx_data_d  = rx_pend_q ? rx_shift_q : rx_data_q;
   end

   // State and datapath registers; reset drops any partial byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         bit_cnt_q  <= '0;
         hold_cnt_q <= '0;
         last_q     <= 1'b0;
         cs_q       <= 1'b1;
         mosi_q     <= 1'b0;
         rx_pend_q  <= 1'b0;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         bit_cnt_q  <= bit_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         last_q     <= last_d;
         cs_q       <= cs_d;
         mosi_q     <= mosi_d;
         rx_pend_q  <= rx_pend_d;
         rx_valid_q <= rx_valid_d;
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - randomized self-checking bench for spi_master against a timeline model
module tb_spi_master;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_last = 1'b0;
   logic       tx_valid = 1'b0;
   logic       miso = 1'b0;
   logic       tx_ready, rx_valid, busy, sclk, cs, mosi;
   logic [7:0] rx_data;

   always #5 clk = ~clk;

   spi_master #(.CLK_DIV(D)) dut (
      .clk      (clk),
      .rst      (rst),
      .tx_data  (tx_data),
      .tx_last  (tx_last),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .busy     (busy),
      .sclk     (sclk),
      .cs       (cs),
      .mosi     (mosi),
      .miso     (miso)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Timeline model: a byte accepted at cycle A occupies cycles A+1 .. A+16*D,
   // then WAIT (non-last) or DONE/GAP for D cycles each (last).
   int         cyc = 0;
   bit         have_txn = 1'b0;
   int         t0 = 0;
   bit         cur_last = 1'b0;
   logic [7:0] cur_tx = 8'h00, cur_rx = 8'h00, cur_miso = 8'h00, prev_rx = 8'h00;
   logic [7:0] next_miso = 8'h00;
   int         acc_cnt = 0;
   logic [13:0] m_now, m_cmp;

   // Monitor state (written only by the monitor process).
   int         mon_rises = 0, mon_rxv = 0, cs_run = 0, last_cs_hi = 0;
   logic       sclk_prev = 1'b0, cs_prev = 1'b1;
   logic [7:0] rxq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
   endtask

   // Returns {cs, sclk, mosi, tx_ready, busy, rx_valid, rx_data} for cycle c.
   function automatic logic [13:0] model_exp(input int c);
      logic cs_e, sclk_e, mosi_e, rdy_e, busy_e, rv_e;
      logic [7:0] rd_e;
      int e;
      cs_e = 1'b1; sclk_e = 1'b0; mosi_e = 1'b0; rdy_e = 1'b1; busy_e = 1'b0;
      rv_e = 1'b0; rd_e = prev_rx;
      if (have_txn) begin
         e = c - t0;
         mosi_e = cur_tx[0];
         if (e < 16*D) begin
            cs_e = 1'b0; sclk_e = ((e / D) % 2) == 1; mosi_e = cur_tx[7 - e/(2*D)];
            rdy_e = 1'b0; busy_e = 1'b1;
         end else if (!cur_last) begin
            cs_e = 1'b0; busy_e = 1'b1;
         end else if (e < 17*D) begin
            cs_e = 1'b0; rdy_e = 1'b0; busy_e = 1'b1;
         end else if (e < 18*D) begin
            rdy_e = 1'b0; busy_e = 1'b1;
         end
         rv_e = (e == 15*D + 1);
         if (e >= 15*D + 1) rd_e = cur_rx;
      end
      return {cs_e, sclk_e, mosi_e, rdy_e, busy_e, rv_e, rd_e};
   endfunction

   function automatic bit model_idle();
      return !have_txn || (cur_last && (cyc - t0) >= 18*D);
   endfunction

   // Model advance: decide acceptance from the model's own readiness.
   always @(posedge clk) begin
      m_now = model_exp(cyc);
      if (rst) begin
         have_txn = 1'b0;
         prev_rx  = 8'h00;
      end else if (tx_valid && m_now[10]) begin
         if (have_txn) prev_rx = cur_rx;
         have_txn = 1'b1;
         t0       = cyc + 1;
         cur_tx   = tx_data;
         cur_last = tx_last;
         cur_miso = next_miso;
`ifdef SPI_MASTER_LOOPBACK_EN
         cur_rx   = tx_data;
`else
         cur_rx   = next_miso;
`endif
         acc_cnt++;
      end
      cyc++;
   end

   // Per-cycle compare against the model, and the bench's slave-side miso drive.
   always @(negedge clk) begin
      m_cmp = model_exp(cyc);
      if (have_txn && (cyc - t0) < 16*D) miso = cur_miso[7 - (cyc - t0)/(2*D)];
      else miso = 1'b0;
      if (!rst)
         check("cycle_outputs", 32'({cs, sclk, mosi, tx_ready, busy, rx_valid, rx_data}), 32'(m_cmp));
   end

   // Event monitor for edge counts, received bytes and cs-high run length.
   always @(negedge clk) begin
      if (sclk === 1'b1 && sclk_prev === 1'b0) mon_rises++;
      if (rx_valid === 1'b1) begin
         mon_rxv++;
         rxq.push_back(rx_data);
      end
      if (cs === 1'b1) cs_run++;
      else begin
         if (cs_prev === 1'b1) last_cs_hi = cs_run;
         cs_run = 0;
      end
      sclk_prev = sclk;
      cs_prev   = cs;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic goto(input int c);
      while (cyc < c) tick();
   endtask

   task automatic send(input logic [7:0] d, input bit last, input logic [7:0] mb, input bit keep);
      int start;
      bit got;
      start = acc_cnt; got = 1'b0;
      tx_data = d; tx_last = last; next_miso = mb; tx_valid = 1'b1;
      for (int i = 0; i < 400 && !got; i++) begin
         tick();
         if (acc_cnt != start) got = 1'b1;
      end
      check("accept_timeout", 32'(got), 1);
      if (!keep) begin
         tx_valid = 1'b0;
         tx_data  = 8'($urandom);
         tx_last  = 1'($urandom);
      end
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 600 && !ok; i++) begin
         if (model_idle()) ok = 1'b1;
         else tick();
      end
      check("idle_timeout", 32'(ok), 1);
   endtask

   initial begin
      #(10 * 90000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, t1, t2, r0, v0, q0;
      logic [7:0] pat, exp_single;
      logic [7:0] exp_burst[3];
      logic [7:0] d;
      bit last;

      // Reset values.
      repeat (3) tick();
      check("rst_cs", 32'(cs), 1);
      check("rst_sclk", 32'(sclk), 0);
      check("rst_mosi", 32'(mosi), 0);
      check("rst_rx_valid", 32'(rx_valid), 0);
      check("rst_rx_data", 32'(rx_data), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_tx_ready", 32'(tx_ready), 1);
      rst = 1'b0;
      repeat (2) tick();

      // Single byte 0xA5 with last; literal timing pins.
      pat = 8'hA5;
`ifdef SPI_MASTER_LOOPBACK_EN
      exp_single = 8'hA5;
`else
      exp_single = 8'h3C;
`endif
      send(8'hA5, 1'b1, 8'h3C, 1'b0);
      t = t0;
      check("single_cs_fall", 32'(cs), 0);
      check("single_bit7", 32'(mosi), 1);
      for (int k = 1; k <= 8; k++) begin
         goto(t + (2*k - 1)*D);
         check("single_sclk_rise", 32'(sclk), 1);
         check("single_mosi_at_rise", 32'(mosi), 32'(pat[8-k]));
      end
      goto(t + 15*D + 1);
      check("single_rx_valid", 32'(rx_valid), 1);
      check("single_rx_data", 32'(rx_data), 32'(exp_single));
      goto(t + 17*D - 1);
      check("single_cs_still_low", 32'(cs), 0);
      tick();
      check("single_cs_rise", 32'(cs), 1);
      goto(t + 18*D - 1);
      check("single_busy_gap", 32'(busy), 1);
      tick();
      check("single_idle_busy", 32'(busy), 0);
      check("single_idle_ready", 32'(tx_ready), 1);

      // Burst of three bytes, last on the third.
`ifdef SPI_MASTER_LOOPBACK_EN
      exp_burst[0] = 8'h3C; exp_burst[1] = 8'hFF; exp_burst[2] = 8'h00;
`else
      exp_burst[0] = 8'h81; exp_burst[1] = 8'h7E; exp_burst[2] = 8'h55;
`endif
      r0 = mon_rises; v0 = mon_rxv; q0 = rxq.size();
      send(8'h3C, 1'b0, 8'h81, 1'b0);
      send(8'hFF, 1'b0, 8'h7E, 1'b0);
      send(8'h00, 1'b1, 8'h55, 1'b0);
      wait_idle();
      check("burst_rises", 32'(mon_rises - r0), 24);
      check("burst_rx_pulses", 32'(mon_rxv - v0), 3);
      for (int i = 0; i < 3; i++)
         if (rxq.size() > q0 + i) check("burst_rx_byte", 32'(rxq[q0+i]), 32'(exp_burst[i]));

      // Stall in WAIT for 100 cycles.
      send(8'h12, 1'b0, 8'hC7, 1'b0);
      goto(t0 + 16*D);
      repeat (100) tick();
      check("stall_cs", 32'(cs), 0);
      check("stall_sclk", 32'(sclk), 0);
      check("stall_ready", 32'(tx_ready), 1);
      send(8'h34, 1'b1, 8'h2B, 1'b0);
      wait_idle();

      // Reset after the 3rd rising edge.
      send(8'hE7, 1'b1, 8'h99, 1'b0);
      goto(t0 + 5*D);
      v0 = mon_rxv;
      #1 rst = 1'b1;
      #1;
      check("midrst_cs", 32'(cs), 1);
      check("midrst_sclk", 32'(sclk), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_mosi", 32'(mosi), 0);
      check("midrst_rx_data", 32'(rx_data), 0);
      tick();
      tick();
      rst = 1'b0;
      repeat (12 * D) tick();
      check("midrst_no_rx_valid", 32'(mon_rxv - v0), 0);
      send(8'h5A, 1'b1, 8'hA3, 1'b0);
      wait_idle();

      // Back-to-back single-byte transactions with tx_valid held high.
      send(8'h96, 1'b1, 8'h0F, 1'b1);
      t1 = t0;
      send(8'h69, 1'b1, 8'hF0, 1'b0);
      t2 = t0;
      check("b2b_accept_spacing", 32'(t2 - t1), 18*D + 1);
      wait_idle();
      check("b2b_cs_high_len", 32'(last_cs_hi), D + 1);

      // Randomized traffic.
      for (int n = 0; n < 40; n++) begin
         d    = 8'($urandom);
         last = ($urandom_range(0, 2) == 0) || (n == 39);
         repeat ($urandom_range(0, 5)) tick();
         send(d, last, 8'($urandom), 1'b0);
      end
      wait_idle();
      repeat (4) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/spi_master.md
# spi_master

Mode-0 SPI master that drives `sclk`, `cs` and `mosi` and samples `miso` from one system clock, transferring MSB-first bytes. It is the initiator end of the link served by the team's `spi_slave`. It is used for chip-to-chip bring-up and for the loopback bench against `spi_slave`. The system side moves bytes through a valid/ready TX port and a one-cycle RX strobe; multi-byte transactions hold `cs` low until a byte marked last completes.

## Interface
- `CLK_DIV`, 4: `clk` cycles per `sclk` half period. Legal values are ≥2. Use ≥4 when driving a `spi_slave` clocked at the same frequency, because of its 2-flop synchronizer.
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `tx_data`  in  8  byte to send
- `tx_last`  in  1  accompanies `tx_data`: deassert `cs` after this byte
- `tx_valid`  in  1  `tx_data`/`tx_last` valid
- `tx_ready`  out  1  byte accepted on a cycle with `tx_valid && tx_ready`
- `rx_data`  out  8  byte captured from `miso`; holds until the next byte
- `rx_valid`  out  1  one-cycle strobe, `rx_data` new; no backpressure
- `busy`  out  1  high in every state except IDLE
- `sclk`  out  1  SPI clock, idle low
- `cs`  out  1  chip select, active low
- `mosi`  out  1  serial data out
- `miso`  in  1  serial data in; bench drives it synchronously

## Operation
- FSM states: IDLE, XFER, WAIT, DONE, GAP.
- **IDLE**
  - `tx_ready`=1, `cs`=1.
  - On accept: load the shift register, latch `tx_last`, drive `mosi`=bit7, set `cs`=0, and enter XFER.
- **XFER**
  - A half-period counter counts 0..`CLK_DIV`-1; `sclk` toggles at each wrap.
  - Rising edge k (k=1..8): sample `miso` into the RX shift register LSB.
  - Falling edge k (k=1..7): drive the next bit on `mosi`.
  - After the 8th falling edge: go to DONE if the latched last flag is set, otherwise go to WAIT.
- **WAIT**
  - `cs`=0, `sclk`=0, `tx_ready`=1.
  - On accept: load the byte, drive `mosi`=bit7, and re-enter XFER with the counter cleared.
  - With no `tx_valid`, the FSM stays in WAIT indefinitely.
- **DONE**: `cs` stays 0 for `CLK_DIV` cycles, then goes to 1 and the FSM enters GAP.
- **GAP**: `cs`=1 for `CLK_DIV` cycles (minimum deselect time), then IDLE.
- `tx_ready` is 0 in XFER, DONE and GAP.
- `rx_data` updates and `rx_valid` pulses exactly once per byte, in the cycle after the 8th rising edge.
- `mosi` holds its last value outside XFER/WAIT; it resets to 0.
- Simultaneous events:
  - `tx_valid` arriving on the same cycle FSM enters IDLE or WAIT is accepted that cycle.
  - `tx_last` is ignored unless accepted with the byte.
- Reset, including mid-transfer, applies immediately (asynchronously):
  - `cs`=1, `sclk`=0, `mosi`=0, `rx_valid`=0, `rx_data`=0x00, `busy`=0.
  - State IDLE, so `tx_ready`=1 once reset is released.
  - The partial byte is discarded and no `rx_valid` is produced.

## Timing
- Accept at cycle A: `cs` falls and bit7 is on `mosi` at A+1 (registered outputs).
- With t=A+1:
  - rising edge k at t+(2k-1)·`CLK_DIV`
  - falling edge k at t+2k·`CLK_DIV`
- `rx_valid` is high at t+15·`CLK_DIV`+1.
- Last byte: `cs` rises at t+17·`CLK_DIV`; IDLE is reached at t+18·`CLK_DIV`.
- Non-last byte: WAIT is entered at t+16·`CLK_DIV`. Back-to-back accept there gives a minimum inter-byte `sclk` low time of `CLK_DIV`+1 cycles.
- Counter width is $clog2(`CLK_DIV`); the bit counter is 3 bits and wraps after bit 8.

## Configuration
- `SPI_MASTER_LOOPBACK_EN`
  - Defined: the internal `miso` sample source is the registered `mosi` value, and the `miso` port is ignored. This is for self-test.
  - Undefined: the `miso` port is sampled. No other behaviour changes.

## Structure
- Shared package `spi_pkg`:
  - FSM state encodings (IDLE=0, XFER=1, WAIT=2, DONE=3, GAP=4, 3-bit)
  - default `CLK_DIV`
  - byte width 8, shared with `spi_slave`.
- Sub-module `spi_clk_gen`:
  - Half-period counter producing `sclk`, plus one-cycle `rise`/`fall` event strobes.
  - Control inputs: enable, clear.
  - The FSM and shift registers stay in `spi_master`.

## Test plan
- **Single byte, loopback** (`CLK_DIV`=4): send 0xA5 with last.
  - `mosi` bits 1,0,1,0,0,1,0,1 at the rising edges.
  - `rx_data`=0xA5 with `rx_valid` at A+62.
  - `cs` low from A+1 to A+69.
- **Burst without loopback**: send 0x3C, 0xFF, 0x00 (last on the third) with `miso` driven by the bench as 0x81, 0x7E, 0x55.
  - `cs` stays low throughout.
  - 24 rising edges; three `rx_valid` pulses with those values.
- **Stall**: send 0x12 non-last, hold `tx_valid` low for 100 cycles, then send 0x34 with last.
  - `cs`=0 and `sclk`=0 for the whole stall; both bytes are sent correctly.
- **Reset mid-transfer**: assert `rst` after the 3rd rising edge.
  - `cs`=1 and `sclk`=0 within the same cycle; no `rx_valid`.
  - A following byte 0x5A completes normally.
- **Back-to-back transactions**: two single-byte last transfers with `tx_valid` held high.
  - The second is accepted only after GAP; the `cs` high interval is ≥`CLK_DIV` cycles.
- **Against `spi_slave`** (same `clk`, `CLK_DIV`=4): master sends 0xC3.
  - Slave RX FIFO holds 0xC3.
